// File: rtl/turbo_pkg.sv
// Shared types and helpers for the 8-bit turbo code path (encoder and decoder).
// Combinational definitions only; no latency.
// No flow control; consumers own their handshakes.
package turbo_pkg;

    // Symbols per frame; the datapath is built for exactly this length.
    localparam int FRAME_LEN_DEF = 8;

    // Interleaver PI = {5,2,7,0,3,6,1,4}; entry j sits at bits [3*j +: 3].
    localparam logic [23:0] PI_TBL = {3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd7, 3'd2, 3'd5};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ENC2    = 2'd1,
        SEARCH  = 2'd2,
        OUTPUT  = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic parity;
        logic s1;
        logic s2;
    } rsc_out_t;

    // Source index feeding RSC2 at interleaved step j.
    function automatic logic [2:0] pi_idx(input logic [2:0] j);
        logic [4:0] base;
        base = {2'b00, j} * 5'd3;
        return PI_TBL[base +: 3];
    endfunction

    // One step of the recursive systematic convolutional code.
    // Feedback a = u^s1^s2, parity = a^s2 (which reduces to u^s1).
    function automatic rsc_out_t rsc_step(input logic u, input logic s1, input logic s2);
        rsc_out_t r;
        r.parity = u ^ s1;
        r.s1     = u ^ s1 ^ s2;
        r.s2     = s1;
        return r;
    endfunction

endpackage

// File: rtl/turbo_rsc_step.sv
// One combinational RSC step: (u, s1, s2) -> (parity, s1', s2').
// Zero latency.
// No flow control; the caller decides when to register the next state.
module turbo_rsc_step
    import turbo_pkg::*;
(
    input  logic u,
    input  logic s1,
    input  logic s2,
    output logic parity,
    output logic s1_nxt,
    output logic s2_nxt
);

    rsc_out_t step_out;

    // Delegate to the package step so encoder and decoder share one definition.
    always_comb begin
        step_out = rsc_step(u, s1, s2);
    end

    assign parity = step_out.parity;
    assign s1_nxt = step_out.s1;
    assign s2_nxt = step_out.s2;

endmodule

// File: rtl/turbo_dec_8bit.sv
// Hard-decision 8-bit turbo frame checker: buffers 8 (sys,p1,p2) triplets, re-encodes, counts parity mismatches.
// out_valid 9 cycles after the last input transfer; up to 9+72 with TURBO_DEC_CORR_EN (single-bit flip search).
// in_ready only while collecting; results held until out_valid & out_ready, then collection resumes.
module turbo_dec_8bit
    import turbo_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sys,
    input  logic             in_p1,
    input  logic             in_p2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] p1_err_cnt,
    output logic [CNT_W-1:0] p2_err_cnt,
    output logic             frame_ok,
    output logic             corrected
);

    // The buffers and interleaver are hard-wired for 8 symbols.
    if (FRAME_LEN != 8 || CNT_W < 4) begin : g_bad_cfg
        $error("turbo_dec_8bit: FRAME_LEN must be 8 and CNT_W must be at least 4");
    end

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN);
    // Steps 0..7 run the encoder; step 8 is the verdict cycle.
    localparam logic [3:0]       STEP_CMP = 4'd8;

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [2:0]       idx;
    logic [3:0]       step;
    logic [7:0]       sys_buf;
    logic [7:0]       p2_buf;
    logic             r1_s1, r1_s2;
    logic             r2_s1, r2_s2;
    logic [CNT_W-1:0] p1_cnt, p2_cnt;
    logic [7:0]       data_q;
    logic             ok_q;

    logic             rsc1_u, rsc1_par, rsc1_s1n, rsc1_s2n;
    logic             rsc2_u, rsc2_par, rsc2_s1n, rsc2_s2n;
    logic [2:0]       j;
    logic [2:0]       pj;
    logic             xfer;
    logic             out_hs;

`ifdef TURBO_DEC_CORR_EN
    logic [7:0]       p1_buf;
    logic [2:0]       trial;
    logic             t_mis1, t_mis2;
    logic             corr_q;
    logic             trial_hit;
`endif

    assign in_ready   = (state == COLLECT);
    assign out_valid  = (state == OUTPUT);
    assign xfer       = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign out_data   = data_q;
    assign p1_err_cnt = p1_cnt;
    assign p2_err_cnt = p2_cnt;
    assign frame_ok   = ok_q;

`ifdef TURBO_DEC_CORR_EN
    assign trial_hit  = !t_mis1 && !t_mis2;
    assign corrected  = corr_q;
`else
    assign corrected  = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Encoder input select: RSC1 sees live input while collecting, RSC2 the interleaved buffer;
    // during a trial both see the buffered word with the trial bit flipped.
    always_comb begin
        j      = step[2:0];
        pj     = pi_idx(step[2:0]);
        rsc1_u = in_sys;
        rsc2_u = sys_buf[pj];
`ifdef TURBO_DEC_CORR_EN
        if (state == SEARCH) begin
            rsc1_u = sys_buf[j] ^ (j == trial);
            rsc2_u = sys_buf[pj] ^ (pj == trial);
        end
`endif
    end

    turbo_rsc_step u_rsc1 (
        .u      (rsc1_u),
        .s1     (r1_s1),
        .s2     (r1_s2),
        .parity (rsc1_par),
        .s1_nxt (rsc1_s1n),
        .s2_nxt (rsc1_s2n)
    );

    turbo_rsc_step u_rsc2 (
        .u      (rsc2_u),
        .s1     (r2_s1),
        .s2     (r2_s2),
        .parity (rsc2_par),
        .s1_nxt (rsc2_s1n),
        .s2_nxt (rsc2_s2n)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: collect 8 symbols, run RSC2, optionally search, then hold the result.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (xfer && idx == 3'd7) state_nxt = ENC2;
            end
            ENC2: begin
                if (step == STEP_CMP) begin
                    state_nxt = OUTPUT;
`ifdef TURBO_DEC_CORR_EN
                    if (p1_cnt != '0 || p2_cnt != '0) state_nxt = SEARCH;
`endif
                end
            end
            SEARCH: begin
`ifdef TURBO_DEC_CORR_EN
                if (step == STEP_CMP && (trial_hit || trial == 3'd7)) state_nxt = OUTPUT;
`else
                state_nxt = COLLECT;
`endif
            end
            OUTPUT: begin
                if (out_hs) state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Datapath: symbol buffers, encoder states, mismatch counters and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            step    <= '0;
            sys_buf <= '0;
            p2_buf  <= '0;
            r1_s1   <= 1'b0;
            r1_s2   <= 1'b0;
            r2_s1   <= 1'b0;
            r2_s2   <= 1'b0;
            p1_cnt  <= '0;
            p2_cnt  <= '0;
            data_q  <= '0;
            ok_q    <= 1'b0;
`ifdef TURBO_DEC_CORR_EN
            p1_buf  <= '0;
            trial   <= '0;
            t_mis1  <= 1'b0;
            t_mis2  <= 1'b0;
            corr_q  <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (xfer) begin
                        sys_buf[idx] <= in_sys;
                        p2_buf[idx]  <= in_p2;
`ifdef TURBO_DEC_CORR_EN
                        p1_buf[idx]  <= in_p1;
`endif
                        r1_s1 <= rsc1_s1n;
                        r1_s2 <= rsc1_s2n;
                        if (rsc1_par != in_p1) p1_cnt <= sat_inc(p1_cnt);
                        idx   <= idx + 3'd1;
                        // RSC2 and the step counter start clean when ENC2 begins.
                        step  <= '0;
                        r2_s1 <= 1'b0;
                        r2_s2 <= 1'b0;
                    end
                end
                ENC2: begin
                    if (step != STEP_CMP) begin
                        r2_s1 <= rsc2_s1n;
                        r2_s2 <= rsc2_s2n;
                        if (rsc2_par != p2_buf[j]) p2_cnt <= sat_inc(p2_cnt);
                        step  <= step + 4'd1;
                    end else begin
                        // Verdict on the received word; a later trial may overwrite it.
                        data_q <= sys_buf;
                        ok_q   <= (p1_cnt == '0) && (p2_cnt == '0);
                        step   <= '0;
                        r1_s1  <= 1'b0;
                        r1_s2  <= 1'b0;
                        r2_s1  <= 1'b0;
                        r2_s2  <= 1'b0;
`ifdef TURBO_DEC_CORR_EN
                        trial  <= '0;
                        t_mis1 <= 1'b0;
                        t_mis2 <= 1'b0;
`endif
                    end
                end
`ifdef TURBO_DEC_CORR_EN
                SEARCH: begin
                    if (step != STEP_CMP) begin
                        r1_s1 <= rsc1_s1n;
                        r1_s2 <= rsc1_s2n;
                        r2_s1 <= rsc2_s1n;
                        r2_s2 <= rsc2_s2n;
                        if (rsc1_par != p1_buf[j]) t_mis1 <= 1'b1;
                        if (rsc2_par != p2_buf[j]) t_mis2 <= 1'b1;
                        step  <= step + 4'd1;
                    end else if (trial_hit) begin
                        data_q <= sys_buf ^ (8'd1 << trial);
                        p1_cnt <= '0;
                        p2_cnt <= '0;
                        ok_q   <= 1'b1;
                        corr_q <= 1'b1;
                    end else begin
                        // Next candidate bit; after the last one the original verdict stands.
                        trial  <= trial + 3'd1;
                        step   <= '0;
                        r1_s1  <= 1'b0;
                        r1_s2  <= 1'b0;
                        r2_s1  <= 1'b0;
                        r2_s2  <= 1'b0;
                        t_mis1 <= 1'b0;
                        t_mis2 <= 1'b0;
                    end
                end
`endif
                OUTPUT: begin
                    if (out_hs) begin
                        p1_cnt <= '0;
                        p2_cnt <= '0;
                        data_q <= '0;
                        ok_q   <= 1'b0;
                        idx    <= '0;
                        r1_s1  <= 1'b0;
                        r1_s2  <= 1'b0;
`ifdef TURBO_DEC_CORR_EN
                        corr_q <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_dec_8bit.sv
// Directed bench for turbo_dec_8bit: clean frames, parity/systematic errors, stalls, backpressure, reset.
// Parity streams below are hand-encoded (bit j = symbol j): 0xA5 -> p1 0x0B, p2 0xBD; 0x3C -> p1 0xF4, p2 0x29.
// Expectations switch on TURBO_DEC_CORR_EN to match the build under test.
module tb_turbo_dec_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_sys;
    logic       in_p1;
    logic       in_p2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] p1_err_cnt;
    logic [3:0] p2_err_cnt;
    logic       frame_ok;
    logic       corrected;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int last_xfer = 0;

`ifdef TURBO_DEC_CORR_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    turbo_dec_8bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sys     (in_sys),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .p1_err_cnt (p1_err_cnt),
        .p2_err_cnt (p2_err_cnt),
        .frame_ok   (frame_ok),
        .corrected  (corrected)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Offer one triplet (called at a negedge); returns at the negedge after the transfer edge.
    task automatic send_sym(input logic s, input logic p1, input logic p2);
        int n;
        n        = 0;
        in_sys   = s;
        in_p1    = p1;
        in_p2    = p2;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_sym: in_ready=%0b required 1 within 100 cycles", in_ready);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        last_xfer = cyc;
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] p1, input logic [7:0] p2,
                              input int gap_at, input int gap_len);
        for (int k = 0; k < 8; k++) begin
            send_sym(s[k], p1[k], p2[k]);
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_sys = ~s[k];
                    in_p1  = 1'b1;
                    in_p2  = 1'b1;
                    @(negedge clk);
                end
            end
        end
    endtask

    // Wait for out_valid, tracking whether in_ready was ever seen high meanwhile.
    task automatic wait_out(output int lat, output bit rdy_seen);
        int n;
        n        = 0;
        rdy_seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (in_ready) rdy_seen = 1'b1;
        lat = cyc - last_xfer;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: out_data=%h required 00", out_data);
        end
        checks++;
        if (p1_err_cnt !== 4'd0 || p2_err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: p1=%0d p2=%0d required 0/0", p1_err_cnt, p2_err_cnt);
        end
        checks++;
        if (frame_ok !== 1'b0 || corrected !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: frame_ok=%b corrected=%b required 0/0", frame_ok, corrected);
        end
    endtask

    task automatic test_zero();
        int lat;
        bit rdy;
        send_frame(8'h00, 8'h00, 8'h00, -1, 0);
        wait_out(lat, rdy);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL zero_latency: %0d cycles required 9", lat);
        end
        checks++;
        if (out_data !== 8'h00 || p1_err_cnt !== 4'd0 || p2_err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL zero_result: data=%h p1=%0d p2=%0d required 00/0/0", out_data, p1_err_cnt, p2_err_cnt);
        end
        checks++;
        if (frame_ok !== 1'b1 || corrected !== 1'b0) begin
            errors++;
            $display("FAIL zero_flags: frame_ok=%b corrected=%b required 1/0", frame_ok, corrected);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_gaps();
        int lat;
        bit rdy;
        send_frame(8'hA5, 8'h0B, 8'hBD, 3, 3);
        wait_out(lat, rdy);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL gaps_latency: %0d cycles required 9", lat);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_in_ready: in_ready seen=%b after last transfer, required 0", rdy);
        end
        checks++;
        if (out_data !== 8'hA5 || frame_ok !== 1'b1 || p1_err_cnt !== 4'd0 || p2_err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL gaps_result: data=%h ok=%b p1=%0d p2=%0d required A5/1/0/0",
                     out_data, frame_ok, p1_err_cnt, p2_err_cnt);
        end
        handshake();
    endtask

    task automatic test_p1_error();
        int lat;
        bit rdy;
        send_frame(8'hA5, 8'h03, 8'hBD, -1, 0);
        wait_out(lat, rdy);
        checks++;
        if (lat != (CORR ? 81 : 9)) begin
            errors++;
            $display("FAIL p1err_latency: %0d cycles required %0d", lat, CORR ? 81 : 9);
        end
        checks++;
        if (out_data !== 8'hA5 || p1_err_cnt !== 4'd1 || p2_err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL p1err_result: data=%h p1=%0d p2=%0d required A5/1/0", out_data, p1_err_cnt, p2_err_cnt);
        end
        checks++;
        if (frame_ok !== 1'b0 || corrected !== 1'b0) begin
            errors++;
            $display("FAIL p1err_flags: frame_ok=%b corrected=%b required 0/0", frame_ok, corrected);
        end
        handshake();
    endtask

    task automatic test_sys_flip();
        int lat;
        bit rdy;
        send_frame(8'hA1, 8'h0B, 8'hBD, -1, 0);
        wait_out(lat, rdy);
        checks++;
        if (lat != (CORR ? 36 : 9)) begin
            errors++;
            $display("FAIL sysflip_latency: %0d cycles required %0d", lat, CORR ? 36 : 9);
        end
        checks++;
        if (out_data !== (CORR ? 8'hA5 : 8'hA1)) begin
            errors++;
            $display("FAIL sysflip_data: data=%h required %h", out_data, CORR ? 8'hA5 : 8'hA1);
        end
        checks++;
        if (p1_err_cnt !== (CORR ? 4'd0 : 4'd5) || p2_err_cnt !== (CORR ? 4'd0 : 4'd5)) begin
            errors++;
            $display("FAIL sysflip_cnt: p1=%0d p2=%0d required %0d/%0d",
                     p1_err_cnt, p2_err_cnt, CORR ? 0 : 5, CORR ? 0 : 5);
        end
        checks++;
        if (frame_ok !== CORR || corrected !== CORR) begin
            errors++;
            $display("FAIL sysflip_flags: frame_ok=%b corrected=%b required %b/%b", frame_ok, corrected, CORR, CORR);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        bit rdy;
        bit bad;
        send_frame(8'h3C, 8'hF4, 8'h29, -1, 0);
        wait_out(lat, rdy);
        bad = 1'b0;
        // Garbage offered while in_ready is low must be ignored.
        in_valid = 1'b1;
        in_sys   = 1'b1;
        in_p1    = 1'b1;
        in_p2    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h3C || frame_ok !== 1'b1 ||
                p1_err_cnt !== 4'd0 || p2_err_cnt !== 4'd0)
                bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: outputs moved during stall (valid=%b rdy=%b data=%h ok=%b) required 1/0/3C/1",
                     out_valid, in_ready, out_data, frame_ok);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || p1_err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b p1=%0d required 0/1/0",
                     out_valid, in_ready, p1_err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int lat;
        bit rdy;
        // sys 1,1,1,1 against all-zero p1: RSC1 parity 1,0,1,1 gives 3 mismatches.
        for (int k = 0; k < 4; k++) send_sym(1'b1, 1'b0, 1'b0);
        checks++;
        if (p1_err_cnt !== 4'd3) begin
            errors++;
            $display("FAIL midrst_partial: p1=%0d required 3", p1_err_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || p1_err_cnt !== 4'd0 || p2_err_cnt !== 4'd0 ||
            out_data !== 8'h00 || frame_ok !== 1'b0) begin
            errors++;
            $display("FAIL midrst_values: rdy=%b vld=%b p1=%0d p2=%0d data=%h ok=%b required 1/0/0/0/00/0",
                     in_ready, out_valid, p1_err_cnt, p2_err_cnt, out_data, frame_ok);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(8'h3C, 8'hF4, 8'h29, -1, 0);
        wait_out(lat, rdy);
        checks++;
        if (out_data !== 8'h3C || p1_err_cnt !== 4'd0 || p2_err_cnt !== 4'd0 || frame_ok !== 1'b1 || lat != 9) begin
            errors++;
            $display("FAIL midrst_next: data=%h p1=%0d p2=%0d ok=%b lat=%0d required 3C/0/0/1/9",
                     out_data, p1_err_cnt, p2_err_cnt, frame_ok, lat);
        end
        handshake();
    endtask

    task automatic test_reset_mid_output();
        int lat;
        bit rdy;
        send_frame(8'h00, 8'h00, 8'h00, -1, 0);
        wait_out(lat, rdy);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || frame_ok !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL outrst: out_valid=%b frame_ok=%b in_ready=%b required 0/0/1", out_valid, frame_ok, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        int lat;
        bit rdy;
        send_frame(8'h00, 8'hFF, 8'hFF, -1, 0);
        wait_out(lat, rdy);
        checks++;
        if (lat != (CORR ? 81 : 9)) begin
            errors++;
            $display("FAIL sat_latency: %0d cycles required %0d", lat, CORR ? 81 : 9);
        end
        checks++;
        if (p1_err_cnt !== 4'd8 || p2_err_cnt !== 4'd8 || out_data !== 8'h00 || frame_ok !== 1'b0 ||
            corrected !== 1'b0) begin
            errors++;
            $display("FAIL sat_result: p1=%0d p2=%0d data=%h ok=%b corr=%b required 8/8/00/0/0",
                     p1_err_cnt, p2_err_cnt, out_data, frame_ok, corrected);
        end
        handshake();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sys    = 1'b0;
        in_p1     = 1'b0;
        in_p2     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_zero();
        test_gaps();
        test_p1_error();
        test_sys_flip();
        test_backpressure();
        test_reset_mid_frame();
        test_reset_mid_output();
        test_saturate();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
